neureka_streamer_sequencer: RTL and testbench
=============================================

NEUREKA_STREAMER_SEQUENCER -- requirements
Module: neureka_streamer_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: mux-settle cycles between select change and start pulse, legal range 0..7.
REQ-002 SHALL have parameter WAIT_FIFO_EMPTY, default 1: when 1, each phase waits for TCDM FIFO empty before its clear.
REQ-003 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: clear_i  in  1  synchronous soft clear; enable_i  in  1  FSM advance enable.
REQ-005 SHALL have ports: job_valid_i  in  1; job_ready_o  out  1; job_mask_i  in  5  {store,streamin,norm,weight,feat}; job_wmem_i  in  1  weights from dedicated port.
REQ-006 SHALL have ports: ld_st_mux_sel_o  out  1; ld_which_mux_sel_o  out  ld_which_t; wmem_sel_o  out  1.
REQ-007 SHALL have ports: start_o  out  1  one-cycle start for selected source/sink; clear_source_o  out  1; clear_sink_o  out  1.
REQ-008 SHALL have ports: src_done_i  in  1; wsrc_done_i  in  1  dedicated-weight source done; sink_done_i  in  1; fifo_empty_i  in  1.
REQ-009 SHALL have ports: busy_o  out  1; done_o  out  1  job-complete pulse; phase_o  out  3  current phase_t.

Function
REQ-010 SHALL implement FSM states IDLE, SELECT, SETTLE, START, WAIT, DRAIN, CLEAR, FINISH.
REQ-011 IDLE: job_ready_o=1; on job_valid_i&job_ready_o SHALL latch job_mask_i into pending and job_wmem_i into wmem_q, go to SELECT.
REQ-012 SELECT SHALL pick first pending phase in order FEAT, WEIGHT, NORM, STREAMIN, STORE; if pending is empty, go to FINISH.
REQ-013 When feat and weight both pending and wmem_q=1, SELECT SHALL pick combined FEAT_WEIGHT (ld_which=LD_FEAT_WEIGHT_SEL).
REQ-014 SELECT SHALL register ld_which_mux_sel_o, ld_st_mux_sel_o (1 only for STORE) and wmem_sel_o (wmem_q for WEIGHT/FEAT_WEIGHT, else 0); outputs hold until next SELECT.
REQ-015 SETTLE SHALL count SETTLE_CYCLES cycles (skipped when 0), then go to START.
REQ-016 START SHALL assert start_o for exactly one cycle, then go to WAIT.
REQ-017 Done inputs SHALL be captured into sticky flags from START cycle onward; a done asserted in the START cycle is not lost.
REQ-018 WAIT SHALL exit when the required done flags are set: src for FEAT/NORM/STREAMIN/non-wmem WEIGHT, wsrc for wmem WEIGHT, src&wsrc for FEAT_WEIGHT, sink for STORE.
REQ-019 DRAIN SHALL wait for fifo_empty_i=1 when WAIT_FIFO_EMPTY=1, else pass through in one cycle.
REQ-020 CLEAR SHALL pulse clear_source_o (load phases) or clear_sink_o (STORE) for one cycle, clear serviced pending bit(s) and sticky flags, return to SELECT.
REQ-021 FINISH SHALL pulse done_o for one cycle and return to IDLE.
REQ-022 busy_o SHALL be 1 in every state except IDLE.
REQ-023 enable_i=0 SHALL freeze state, counter and sticky flags and force start_o, clear_*_o, done_o to 0; done inputs are still captured.
REQ-024 A job with job_mask_i=0 SHALL complete: IDLE, SELECT, FINISH, with done_o two cycles after acceptance.
REQ-025 clear_i SHALL have priority over enable_i and return all state and outputs to reset values next cycle, including mid-job.

Reset
REQ-026 On rst_ni low, all outputs SHALL be 0 except job_ready_o=1, ld_which_mux_sel_o=LD_FEAT_SEL, phase_o=PH_NONE; pending, wmem_q, counter and flags 0; state IDLE.

Structure
REQ-027 phase_t (PH_NONE, PH_FEAT, PH_WEIGHT, PH_FEAT_WEIGHT, PH_NORM, PH_STREAMIN, PH_STORE) and job-mask bit indices SHALL live in neureka_package, reusing ld_which_t.
REQ-028 The design SHALL be a single module with no sub-modules.

Verification
REQ-029 Mask 5'b00001, src_done 3 cycles after start_o -> ld_which=FEAT, one start_o, one clear_source_o, done_o, busy_o low after FINISH.
REQ-030 Mask 5'b00011, wmem=1 -> single FEAT_WEIGHT phase, wmem_sel_o=1; wsrc_done alone does not exit WAIT; after src_done, one clear_source_o.
REQ-031 Mask 5'b11111, wmem=0 -> phases FEAT, WEIGHT, NORM, STREAMIN, STORE in order; ld_st_mux_sel_o=1 only during STORE; clear_sink_o only once.
REQ-032 STORE with fifo_empty_i=0 for 10 cycles after sink_done -> clear_sink_o delayed until fifo_empty_i=1.
REQ-033 clear_i pulsed in WAIT of mask 5'b00111 -> next cycle IDLE, reset outputs, no done_o; new job accepted afterwards.
REQ-034 enable_i low for 5 cycles in SETTLE with SETTLE_CYCLES=3, src_done pulsed during freeze after START -> start_o delayed 5 cycles, done still honoured.

Source files
------------

// File: rtl/neureka_package.sv
// Shared types for the NEureka streamer sequencer: load-mux selector, phase
// codes, job-mask bit positions, FSM states and phase helper functions.
package neureka_package;

  localparam int unsigned JOB_MASK_W       = 5;
  localparam int unsigned JOB_FEAT_IDX     = 0;
  localparam int unsigned JOB_WEIGHT_IDX   = 1;
  localparam int unsigned JOB_NORM_IDX     = 2;
  localparam int unsigned JOB_STREAMIN_IDX = 3;
  localparam int unsigned JOB_STORE_IDX    = 4;

  typedef enum logic [2:0] {
    LD_FEAT_SEL        = 3'd0,
    LD_WEIGHT_SEL      = 3'd1,
    LD_FEAT_WEIGHT_SEL = 3'd2,
    LD_NORM_SEL        = 3'd3,
    LD_STREAMIN_SEL    = 3'd4
  } ld_which_t;

  typedef enum logic [2:0] {
    PH_NONE        = 3'd0,
    PH_FEAT        = 3'd1,
    PH_WEIGHT      = 3'd2,
    PH_FEAT_WEIGHT = 3'd3,
    PH_NORM        = 3'd4,
    PH_STREAMIN    = 3'd5,
    PH_STORE       = 3'd6
  } phase_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    SETTLE = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    DRAIN  = 3'd5,
    CLEAR  = 3'd6,
    FINISH = 3'd7
  } seq_state_t;

  // Fixed service order; feat+weight merge into one phase when weights come
  // from the dedicated memory port, since both sources then run in parallel.
  function automatic phase_t pick_phase(input logic [JOB_MASK_W-1:0] pend,
                                        input logic wmem);
    phase_t ph;
    ph = PH_NONE;
    if (pend[JOB_FEAT_IDX] && pend[JOB_WEIGHT_IDX] && wmem) ph = PH_FEAT_WEIGHT;
    else if (pend[JOB_FEAT_IDX])                            ph = PH_FEAT;
    else if (pend[JOB_WEIGHT_IDX])                          ph = PH_WEIGHT;
    else if (pend[JOB_NORM_IDX])                            ph = PH_NORM;
    else if (pend[JOB_STREAMIN_IDX])                        ph = PH_STREAMIN;
    else if (pend[JOB_STORE_IDX])                           ph = PH_STORE;
    return ph;
  endfunction

  // Pending bits retired when a phase completes.
  function automatic logic [JOB_MASK_W-1:0] phase_mask(input phase_t ph);
    logic [JOB_MASK_W-1:0] m;
    m = '0;
    case (ph)
      PH_FEAT:        m[JOB_FEAT_IDX] = 1'b1;
      PH_WEIGHT:      m[JOB_WEIGHT_IDX] = 1'b1;
      PH_FEAT_WEIGHT: begin
        m[JOB_FEAT_IDX]   = 1'b1;
        m[JOB_WEIGHT_IDX] = 1'b1;
      end
      PH_NORM:        m[JOB_NORM_IDX] = 1'b1;
      PH_STREAMIN:    m[JOB_STREAMIN_IDX] = 1'b1;
      PH_STORE:       m[JOB_STORE_IDX] = 1'b1;
      default:        m = '0;
    endcase
    return m;
  endfunction

  // Load-mux setting for a phase; STORE does not use the load mux, so it
  // keeps whatever selection was last applied.
  function automatic ld_which_t phase_ld_which(input phase_t ph, input ld_which_t cur);
    ld_which_t sel;
    sel = cur;
    case (ph)
      PH_FEAT:        sel = LD_FEAT_SEL;
      PH_WEIGHT:      sel = LD_WEIGHT_SEL;
      PH_FEAT_WEIGHT: sel = LD_FEAT_WEIGHT_SEL;
      PH_NORM:        sel = LD_NORM_SEL;
      PH_STREAMIN:    sel = LD_STREAMIN_SEL;
      default:        sel = cur;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/neureka_streamer_sequencer.sv
// Sequences the streamer through the load/store phases of one job: selects
// the mux path, lets it settle, starts the source/sink, waits for completion
// and FIFO drain, then clears the serviced path before the next phase.
module neureka_streamer_sequencer
  import neureka_package::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 1,
  parameter int unsigned WAIT_FIFO_EMPTY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [JOB_MASK_W-1:0] job_mask_i,
  input  logic                  job_wmem_i,
  output logic                  ld_st_mux_sel_o,
  output ld_which_t             ld_which_mux_sel_o,
  output logic                  wmem_sel_o,
  output logic                  start_o,
  output logic                  clear_source_o,
  output logic                  clear_sink_o,
  input  logic                  src_done_i,
  input  logic                  wsrc_done_i,
  input  logic                  sink_done_i,
  input  logic                  fifo_empty_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2:0]            phase_o
);

  localparam logic [2:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 3'd0 : 3'(SETTLE_CYCLES - 1);

  seq_state_t            state_q, state_d;
  logic [JOB_MASK_W-1:0] pending_q, pending_d;
  logic                  wmem_q, wmem_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  src_q, src_d;
  logic                  wsrc_q, wsrc_d;
  logic                  sink_q, sink_d;
  phase_t                phase_q, phase_d;
  ld_which_t             ld_which_q, ld_which_d;
  logic                  ld_st_q, ld_st_d;
  logic                  wmem_sel_q, wmem_sel_d;
  phase_t                next_ph;
  logic                  req_met;

  // Completion condition of the active phase from the sticky done flags.
  always_comb begin
    req_met = 1'b1;
    case (phase_q)
      PH_FEAT, PH_NORM, PH_STREAMIN: req_met = src_q;
      PH_WEIGHT:                     req_met = wmem_q ? wsrc_q : src_q;
      PH_FEAT_WEIGHT:                req_met = src_q & wsrc_q;
      PH_STORE:                      req_met = sink_q;
      default:                       req_met = 1'b1;
    endcase
  end

  // Next-state logic; done capture runs even while disabled so no pulse is lost.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    wmem_d     = wmem_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    wsrc_d     = wsrc_q;
    sink_d     = sink_q;
    phase_d    = phase_q;
    ld_which_d = ld_which_q;
    ld_st_d    = ld_st_q;
    wmem_sel_d = wmem_sel_q;
    next_ph    = pick_phase(pending_q, wmem_q);

    if (state_q == START || state_q == WAIT || state_q == DRAIN) begin
      src_d  = src_q  | src_done_i;
      wsrc_d = wsrc_q | wsrc_done_i;
      sink_d = sink_q | sink_done_i;
    end

    if (clear_i) begin
      state_d    = IDLE;
      pending_d  = '0;
      wmem_d     = 1'b0;
      cnt_d      = 3'd0;
      src_d      = 1'b0;
      wsrc_d     = 1'b0;
      sink_d     = 1'b0;
      phase_d    = PH_NONE;
      ld_which_d = LD_FEAT_SEL;
      ld_st_d    = 1'b0;
      wmem_sel_d = 1'b0;
    end else if (state_q == IDLE) begin
      // The handshake completes whenever ready is high, so acceptance is
      // honoured even while the sequencer is disabled.
      if (job_valid_i) begin
        pending_d = job_mask_i;
        wmem_d    = job_wmem_i;
        state_d   = SELECT;
      end
    end else if (enable_i) begin
      case (state_q)
        SELECT: begin
          phase_d = next_ph;
          if (next_ph == PH_NONE) begin
            state_d = FINISH;
          end else begin
            ld_which_d = phase_ld_which(next_ph, ld_which_q);
            ld_st_d    = (next_ph == PH_STORE);
            wmem_sel_d = (next_ph == PH_WEIGHT || next_ph == PH_FEAT_WEIGHT) ? wmem_q : 1'b0;
            cnt_d      = 3'd0;
            state_d    = (SETTLE_CYCLES == 0) ? START : SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = 3'd0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        START:  state_d = WAIT;
        WAIT:   if (req_met) state_d = DRAIN;
        DRAIN:  if (WAIT_FIFO_EMPTY == 0 || fifo_empty_i) state_d = CLEAR;
        CLEAR: begin
          pending_d = pending_q & ~phase_mask(phase_q);
          src_d     = 1'b0;
          wsrc_d    = 1'b0;
          sink_d    = 1'b0;
          state_d   = SELECT;
        end
        FINISH: begin
          wmem_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and job-context registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      wmem_q     <= 1'b0;
      cnt_q      <= 3'd0;
      src_q      <= 1'b0;
      wsrc_q     <= 1'b0;
      sink_q     <= 1'b0;
      phase_q    <= PH_NONE;
      ld_which_q <= LD_FEAT_SEL;
      ld_st_q    <= 1'b0;
      wmem_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      wmem_q     <= wmem_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      wsrc_q     <= wsrc_d;
      sink_q     <= sink_d;
      phase_q    <= phase_d;
      ld_which_q <= ld_which_d;
      ld_st_q    <= ld_st_d;
      wmem_sel_q <= wmem_sel_d;
    end
  end

  // Pulse outputs are suppressed while disabled so a frozen state never repeats them.
  always_comb begin
    job_ready_o        = (state_q == IDLE);
    busy_o             = (state_q != IDLE);
    start_o            = (state_q == START) && enable_i;
    clear_source_o     = (state_q == CLEAR) && enable_i && (phase_q != PH_STORE);
    clear_sink_o       = (state_q == CLEAR) && enable_i && (phase_q == PH_STORE);
    done_o             = (state_q == FINISH) && enable_i;
    ld_st_mux_sel_o    = ld_st_q;
    ld_which_mux_sel_o = ld_which_q;
    wmem_sel_o         = wmem_sel_q;
    phase_o            = phase_q;
  end

endmodule

// File: tb/tb_neureka_streamer_sequencer.sv
// Randomized bench for neureka_streamer_sequencer with a job-level reference
// model: the expected phase list is derived from the mask, and every event
// time is derived from the settle/done/FIFO latencies of each phase.
module tb_neureka_streamer_sequencer;
  import neureka_package::*;

  localparam int SETTLE = 3;

  logic       clk = 1'b0;
  logic       rst_n, clear, enable, job_valid, job_wmem;
  logic [4:0] job_mask;
  logic       src_done, wsrc_done, sink_done, fifo_empty;
  logic       job_ready, ld_st, wmem_sel, start, clr_src, clr_sink, busy, done;
  ld_which_t  ld_which;
  logic [2:0] phase;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int ph;
    int ldw;   // -1: load mux not relevant for this phase
    int ldst;
    int wsel;
    int nsrc;
    int nwsrc;
    int nsink;
  } exp_ph_t;

  exp_ph_t plan[$];

  neureka_streamer_sequencer #(.SETTLE_CYCLES(SETTLE), .WAIT_FIFO_EMPTY(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
    .job_valid_i(job_valid), .job_ready_o(job_ready), .job_mask_i(job_mask),
    .job_wmem_i(job_wmem), .ld_st_mux_sel_o(ld_st), .ld_which_mux_sel_o(ld_which),
    .wmem_sel_o(wmem_sel), .start_o(start), .clear_source_o(clr_src),
    .clear_sink_o(clr_sink), .src_done_i(src_done), .wsrc_done_i(wsrc_done),
    .sink_done_i(sink_done), .fifo_empty_i(fifo_empty), .busy_o(busy),
    .done_o(done), .phase_o(phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference plan: service order feat, weight, norm, streamin, store, with
  // feat+weight merged when weights come from the dedicated port.
  function automatic void build_plan(input logic [4:0] mask, input logic wmem);
    logic [4:0] pend;
    exp_ph_t e;
    pend = mask;
    plan.delete();
    while (pend != 5'd0) begin
      e = '{ph: 0, ldw: -1, ldst: 0, wsel: 0, nsrc: 0, nwsrc: 0, nsink: 0};
      if (pend[0] && pend[1] && wmem) begin
        e.ph = int'(PH_FEAT_WEIGHT); e.ldw = int'(LD_FEAT_WEIGHT_SEL);
        e.wsel = 1; e.nsrc = 1; e.nwsrc = 1; pend[1:0] = 2'b00;
      end else if (pend[0]) begin
        e.ph = int'(PH_FEAT); e.ldw = int'(LD_FEAT_SEL); e.nsrc = 1; pend[0] = 1'b0;
      end else if (pend[1]) begin
        e.ph = int'(PH_WEIGHT); e.ldw = int'(LD_WEIGHT_SEL); e.wsel = int'(wmem);
        e.nsrc = int'(!wmem); e.nwsrc = int'(wmem); pend[1] = 1'b0;
      end else if (pend[2]) begin
        e.ph = int'(PH_NORM); e.ldw = int'(LD_NORM_SEL); e.nsrc = 1; pend[2] = 1'b0;
      end else if (pend[3]) begin
        e.ph = int'(PH_STREAMIN); e.ldw = int'(LD_STREAMIN_SEL); e.nsrc = 1; pend[3] = 1'b0;
      end else begin
        e.ph = int'(PH_STORE); e.ldst = 1; e.nsink = 1; pend[4] = 1'b0;
      end
      plan.push_back(e);
    end
  endfunction

  // One full job; fifo_extra < 0 picks a random FIFO drain delay per phase.
  task automatic run_job(input logic [4:0] mask, input logic wmem, input int fifo_extra);
    int k, exp_start, exp_clear, pidx, prev_end, fifo_until, lastd, extra, busy_ok, finished;
    int t_src, t_wsrc, t_sink;
    exp_ph_t e;
    build_plan(mask, wmem);
    @(negedge clk);
    check_eq("idle_ready", int'(job_ready), 1);
    check_eq("idle_busy", int'(busy), 0);
    job_valid = 1'b1; job_mask = mask; job_wmem = wmem; k = cyc;
    @(negedge clk);
    job_valid = 1'b0; job_mask = 5'($urandom); job_wmem = 1'($urandom);
    exp_start = k + 1 + SETTLE + 1; exp_clear = -1; prev_end = k;
    pidx = 0; fifo_until = -1; busy_ok = 1; finished = 0;
    t_src = -1; t_wsrc = -1; t_sink = -1;
    e = '{ph: 0, ldw: -1, ldst: 0, wsel: 0, nsrc: 0, nwsrc: 0, nsink: 0};
    for (int n = 0; n < 400 && finished == 0; n++) begin
      if (!busy) busy_ok = 0;
      if (start) begin
        check_eq("start_cycle", cyc, exp_start);
        if (pidx < plan.size()) begin
          e = plan[pidx];
          check_eq("phase", int'(phase), e.ph);
          check_eq("ld_st_sel", int'(ld_st), e.ldst);
          check_eq("wmem_sel", int'(wmem_sel), e.wsel);
          if (e.ldw >= 0) check_eq("ld_which", int'(ld_which), e.ldw);
          t_src  = e.nsrc  ? cyc + int'($urandom_range(0, 4)) : -1;
          t_wsrc = e.nwsrc ? cyc + int'($urandom_range(0, 4)) : -1;
          t_sink = e.nsink ? cyc + int'($urandom_range(0, 4)) : -1;
          lastd = cyc;
          if (t_src > lastd) lastd = t_src;
          if (t_wsrc > lastd) lastd = t_wsrc;
          if (t_sink > lastd) lastd = t_sink;
          extra = (fifo_extra >= 0) ? fifo_extra : int'($urandom_range(0, 3));
          fifo_until = lastd + 2 + extra;
          exp_clear = fifo_until + 1;
        end else begin
          check_eq("start_count", pidx + 1, plan.size());
        end
      end
      if (clr_src || clr_sink) begin
        check_eq("clear_cycle", cyc, exp_clear);
        check_eq("clear_sink_kind", int'(clr_sink), e.nsink);
        check_eq("clear_src_kind", int'(clr_src), 1 - e.nsink);
        pidx++; prev_end = cyc; exp_start = cyc + 1 + SETTLE + 1;
        fifo_until = -1; t_src = -1; t_wsrc = -1; t_sink = -1;
      end
      if (done) begin
        check_eq("done_cycle", cyc, prev_end + 2);
        check_eq("phases_done", pidx, plan.size());
        check_eq("phase_finish", int'(phase), int'(PH_NONE));
        finished = 1;
      end
      src_done  = (cyc == t_src)  || (t_src  < 0 && fifo_until >= 0 && $urandom_range(0, 3) == 0);
      wsrc_done = (cyc == t_wsrc) || (t_wsrc < 0 && fifo_until >= 0 && $urandom_range(0, 3) == 0);
      sink_done = (cyc == t_sink);
      fifo_empty = (fifo_until < 0) || (cyc >= fifo_until);
      @(negedge clk);
    end
    check_eq("done_seen", finished, 1);
    check_eq("busy_during_job", busy_ok, 1);
    src_done = 1'b0; wsrc_done = 1'b0; sink_done = 1'b0; fifo_empty = 1'b1;
    check_eq("post_busy", int'(busy), 0);
    check_eq("post_ready", int'(job_ready), 1);
  endtask

  task automatic clear_mid_job();
    int seen;
    @(negedge clk);
    job_valid = 1'b1; job_mask = 5'b00111; job_wmem = 1'b0;
    @(negedge clk);
    job_valid = 1'b0;
    for (int n = 0; n < 50 && !start; n++) @(negedge clk);
    check_eq("clr_test_start", int'(start), 1);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_eq("clr_busy", int'(busy), 0);
    check_eq("clr_ready", int'(job_ready), 1);
    check_eq("clr_phase", int'(phase), int'(PH_NONE));
    check_eq("clr_ld_which", int'(ld_which), int'(LD_FEAT_SEL));
    check_eq("clr_wmem_sel", int'(wmem_sel), 0);
    check_eq("clr_ld_st", int'(ld_st), 0);
    seen = 0;
    src_done = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (done || start || clr_src || clr_sink || busy) seen = 1;
      @(negedge clk);
      src_done = 1'b0;
    end
    check_eq("clr_quiet", seen, 0);
  endtask

  task automatic freeze_test();
    int k, s, got;
    @(negedge clk);
    job_valid = 1'b1; job_mask = 5'b00001; job_wmem = 1'b0; k = cyc;
    @(negedge clk);
    job_valid = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    got = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (start) got = 1;
    end
    check_eq("frz_no_start", got, 0);
    @(negedge clk);
    enable = 1'b1;
    for (int n = 0; n < 30 && !start; n++) @(negedge clk);
    check_eq("frz_start_cycle", cyc, k + 1 + SETTLE + 1 + 5);
    s = cyc;
    @(negedge clk); enable = 1'b0;
    @(negedge clk); src_done = 1'b1;
    @(negedge clk); src_done = 1'b0;
    @(negedge clk);
    @(negedge clk); enable = 1'b1;
    for (int n = 0; n < 30 && !clr_src; n++) @(negedge clk);
    check_eq("frz_clear_cycle", cyc, s + 7);
    for (int n = 0; n < 10 && !done; n++) @(negedge clk);
    check_eq("frz_done_cycle", cyc, s + 9);
    @(negedge clk);
    check_eq("frz_idle", int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; enable = 1'b1; job_valid = 1'b0;
    job_mask = 5'd0; job_wmem = 1'b0; src_done = 1'b0; wsrc_done = 1'b0;
    sink_done = 1'b0; fifo_empty = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", int'(job_ready), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_start", int'(start), 0);
    check_eq("rst_clr_src", int'(clr_src), 0);
    check_eq("rst_clr_sink", int'(clr_sink), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_phase", int'(phase), int'(PH_NONE));
    check_eq("rst_ld_which", int'(ld_which), int'(LD_FEAT_SEL));
    check_eq("rst_ld_st", int'(ld_st), 0);
    check_eq("rst_wmem_sel", int'(wmem_sel), 0);
    rst_n = 1'b1;

    run_job(5'b00000, 1'b0, -1);
    run_job(5'b00001, 1'b0, 0);
    run_job(5'b00011, 1'b1, -1);
    run_job(5'b11111, 1'b0, -1);
    run_job(5'b11111, 1'b1, -1);
    run_job(5'b10000, 1'b0, 10);
    clear_mid_job();
    run_job(5'b00111, 1'b0, -1);
    freeze_test();
    for (int i = 0; i < 12; i++) run_job(5'($urandom), 1'($urandom), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
